// File: rtl/flit_arb_mux_if.sv
// flit_arb_mux_if
//   Bundles the flit handshake between the input VC buffers, the arbitrating
//   mux and the output link.
//   slave  : the mux side  (consumes idata/ivalid/ivch/oready,
//                           drives iready/odata/ovalid/ovch/ogrant)
//   master : the environment side (opposite directions)
//   Signals:
//     idata  [NPORT*DATAW]  input flits, port p at [p*DATAW +: DATAW]
//     ivalid [NPORT]        per-port flit valid
//     ivch   [NPORT*VCHW]   per-port VC id
//     iready [NPORT]        per-port accept
//     odata  [DATAW]        registered output flit
//     ovalid                output flit valid
//     ovch   [VCHW]         output VC id
//     oready                downstream accept
//     ogrant [NPORT]        one-hot locked port, zero when idle
interface flit_arb_mux_if #(
  parameter int NPORT = 4,
  parameter int DATAW = 66,
  parameter int VCHW  = 2
);
  logic [NPORT*DATAW-1:0] idata;
  logic [NPORT-1:0]       ivalid;
  logic [NPORT*VCHW-1:0]  ivch;
  logic [NPORT-1:0]       iready;
  logic [DATAW-1:0]       odata;
  logic                   ovalid;
  logic [VCHW-1:0]        ovch;
  logic                   oready;
  logic [NPORT-1:0]       ogrant;

  modport slave (
    input  idata, ivalid, ivch, oready,
    output iready, odata, ovalid, ovch, ogrant
  );

  modport master (
    output idata, ivalid, ivch, oready,
    input  iready, odata, ovalid, ovch, ogrant
  );
endinterface

// File: rtl/flit_arb_mux.sv
// flit_arb_mux
//   N-input flit multiplexer. Arbitrates round-robin between ports on packet
//   boundaries (HEAD flits), then locks the output to the winning port until
//   its TAIL flit transfers. Flits pass through a single registered output
//   stage with valid/ready backpressure.
//   Flit type lives in the two MSBs: 01 HEAD, 10 DATA, 11 TAIL, 00 NONE.
//   Ports:
//     clk    in   rising-edge clock
//     rst_   in   asynchronous active-low reset
//     bus    slave modport of flit_arb_mux_if (input flits, output flit,
//            handshakes, grant)
//     ocount out  32-bit output-transfer counter (only with FLIT_MUX_CNT_EN)
//   Optional feature macro: FLIT_MUX_CNT_EN adds the ocount port and counter.
module flit_arb_mux #(
  parameter int NPORT = 4,
  parameter int DATAW = 66,
  parameter int VCHW  = 2
) (
  input  logic              clk,
  input  logic              rst_,
  flit_arb_mux_if.slave     bus
`ifdef FLIT_MUX_CNT_EN
  ,
  output logic [31:0]       ocount
`endif
);

  localparam int PW = (NPORT > 1) ? $clog2(NPORT) : 1;

  typedef enum logic {
    ST_IDLE,
    ST_LOCK
  } state_t;

  typedef enum logic [1:0] {
    FT_NONE = 2'b00,
    FT_HEAD = 2'b01,
    FT_DATA = 2'b10,
    FT_TAIL = 2'b11
  } flit_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [PW-1:0]     r_rr_ptr;
  logic [PW-1:0]     r_lock_port;

  logic [DATAW-1:0]  r_odata;
  logic              r_ovalid;
  logic [VCHW-1:0]   r_ovch;

  logic              w_load_ok;
  logic [NPORT-1:0]  w_head;
  logic              w_win_found;
  logic [PW-1:0]     w_winner;
  logic [PW-1:0]     w_sel;
  logic [DATAW-1:0]  w_sel_data;
  logic [VCHW-1:0]   w_sel_vch;
  logic [NPORT-1:0]  w_iready;
  logic [NPORT-1:0]  w_ogrant;
  logic              w_lock_take;
  logic              w_tail_xfer;
  logic              w_in_xfer;

  function automatic logic [NPORT-1:0] f_onehot(input logic [PW-1:0] idx);
    logic [NPORT-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  function automatic logic [PW-1:0] f_next_port(input logic [PW-1:0] idx);
    if (idx == PW'(NPORT - 1)) return '0;
    return idx + PW'(1);
  endfunction

  // Output stage may take a new flit when empty or draining this cycle.
  assign w_load_ok = !r_ovalid || bus.oready;

  // HEAD candidates for arbitration.
  always_comb begin
    w_head = '0;
    for (int unsigned p = 0; p < NPORT; p++) begin
      w_head[p] = bus.ivalid[p] &&
                  (bus.idata[p*DATAW + DATAW - 2 +: 2] == FT_HEAD);
    end
  end

  // Round-robin search: first candidate at or after r_rr_ptr, wrapping.
  always_comb begin
    int unsigned   idx;
    logic [PW-1:0] idx_w;
    w_win_found = 1'b0;
    w_winner    = '0;
    idx         = 0;
    idx_w       = '0;
    for (int unsigned k = 0; k < NPORT; k++) begin
      idx = 32'(r_rr_ptr) + k;
      if (idx >= NPORT) idx = idx - NPORT;
      idx_w = idx[PW-1:0];
      if (!w_win_found && w_head[idx_w]) begin
        w_win_found = 1'b1;
        w_winner    = idx_w;
      end
    end
  end

  // Input mux source: locked port while in a packet, arbitration winner otherwise.
  assign w_sel = (r_state == ST_LOCK) ? r_lock_port : w_winner;

  always_comb begin
    w_sel_data = '0;
    w_sel_vch  = '0;
    for (int unsigned p = 0; p < NPORT; p++) begin
      if (w_sel == p[PW-1:0]) begin
        w_sel_data = bus.idata[p*DATAW +: DATAW];
        w_sel_vch  = bus.ivch[p*VCHW +: VCHW];
      end
    end
  end

  // Computed from inputs directly (not from w_iready) so the FSM block
  // below has no feedback through its own outputs.
  assign w_tail_xfer = (r_state == ST_LOCK) && w_load_ok &&
                       bus.ivalid[r_lock_port] &&
                       (w_sel_data[DATAW-1 -: 2] == FT_TAIL);

  // FSM next state and handshake outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_iready    = '0;
    w_ogrant    = '0;
    w_lock_take = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_win_found && w_load_ok) begin
          w_iready    = f_onehot(w_winner);
          w_lock_take = 1'b1;
          w_state_nxt = ST_LOCK;
        end
      end
      ST_LOCK: begin
        w_ogrant = f_onehot(r_lock_port);
        w_iready = f_onehot(r_lock_port) & {NPORT{w_load_ok}};
        if (w_tail_xfer) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    // Hold off acceptance while reset is asserted so nothing is granted
    // before the registers are released.
    if (!rst_) w_iready = '0;
  end

  assign w_in_xfer = |(bus.ivalid & w_iready);

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_lock_port <= '0;
      r_rr_ptr    <= '0;
    end else begin
      if (w_lock_take) r_lock_port <= w_winner;
      if (w_tail_xfer) r_rr_ptr    <= f_next_port(r_lock_port);
    end
  end

  // Registered output stage.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_odata  <= '0;
      r_ovalid <= 1'b0;
      r_ovch   <= '0;
    end else if (w_in_xfer) begin
      r_odata  <= w_sel_data;
      r_ovch   <= w_sel_vch;
      r_ovalid <= 1'b1;
    end else if (bus.oready) begin
      r_ovalid <= 1'b0;
    end
  end

`ifdef FLIT_MUX_CNT_EN
  logic [31:0] r_ocount;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_)                       r_ocount <= '0;
    else if (r_ovalid && bus.oready) r_ocount <= r_ocount + 32'd1;
  end

  assign ocount = r_ocount;
`endif

  assign bus.iready = w_iready;
  assign bus.ogrant = w_ogrant;
  assign bus.odata  = r_odata;
  assign bus.ovalid = r_ovalid;
  assign bus.ovch   = r_ovch;

endmodule

// File: tb/tb_flit_arb_mux.sv
`timescale 1ns/1ps
module tb_flit_arb_mux;
  localparam int NP = 4;
  localparam int DW = 66;
  localparam int VW = 2;
  localparam logic [1:0] T_HEAD = 2'b01;
  localparam logic [1:0] T_DATA = 2'b10;
  localparam logic [1:0] T_TAIL = 2'b11;

  logic clk  = 1'b0;
  logic rst_ = 1'b1;
  always #5 clk = ~clk;

  flit_arb_mux_if #(.NPORT(NP), .DATAW(DW), .VCHW(VW)) bus ();
`ifdef FLIT_MUX_CNT_EN
  logic [31:0] ocount;
`endif

  flit_arb_mux #(.NPORT(NP), .DATAW(DW), .VCHW(VW)) dut (
    .clk  (clk),
    .rst_ (rst_),
    .bus  (bus.slave)
`ifdef FLIT_MUX_CNT_EN
    ,
    .ocount (ocount)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Reference model state: locked port (-1 when idle), pointer, output register.
  int          m_lock = -1;
  int          m_ptr  = 0;
  logic        m_ov   = 1'b0;
  logic [65:0] m_od   = '0;
  logic [1:0]  m_ovc  = '0;

  typedef logic [67:0] fq_t [$];   // {vch, flit}
  fq_t q [NP];
  int valid_pct = 100;
  int or_pct    = 100;
  int cyc       = 0;
  int serial    = 0;
  logic [65:0] out_q [$];
  int          out_cyc [$];
  logic [65:0] exp_l [$];

  typedef struct {
    logic [3:0] v;
    logic [7:0] ty;
    int         prev;
    logic [3:0] er;
  } vec_t;
  vec_t tv [10];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic push_flit(input int p, input logic [1:0] ty, input logic [1:0] vch);
    logic [43:0] r;
    logic [65:0] f;
    r = {12'($urandom), $urandom};
    f = {ty, r, 16'(serial), 4'(p)};
    serial++;
    q[p].push_back({vch, f});
    exp_l.push_back(f);
  endtask

  task automatic push_pkt(input int p, input int nd);
    logic [1:0] vch;
    vch = 2'($urandom_range(3));
    push_flit(p, T_HEAD, vch);
    for (int i = 0; i < nd; i++) push_flit(p, T_DATA, vch);
    push_flit(p, T_TAIL, vch);
  endtask

  task automatic log_clear();
    out_q.delete();
    out_cyc.delete();
    exp_l.delete();
  endtask

  task automatic drive();
    logic [95:0] junk;
    for (int p = 0; p < NP; p++) begin
      if (q[p].size() > 0 && $urandom_range(99) < valid_pct) begin
        bus.ivalid[p]          = 1'b1;
        bus.idata[p*DW +: DW]  = q[p][0][65:0];
        bus.ivch[p*VW +: VW]   = q[p][0][67:66];
      end else begin
        junk                   = {$urandom, $urandom, $urandom};
        bus.ivalid[p]          = 1'b0;
        bus.idata[p*DW +: DW]  = junk[65:0];
        bus.ivch[p*VW +: VW]   = junk[95:94];
      end
    end
    bus.oready = ($urandom_range(99) < or_pct);
  endtask

  // Check DUT against the model, then advance the model by the coming edge.
  task automatic model_step();
    logic [NP-1:0] v, er, eg, acc;
    logic          load_ok;
    logic [65:0]   f;
    int            win, ap;
    v       = bus.ivalid;
    load_ok = !m_ov || bus.oready;
    er      = '0;
    eg      = '0;
    win     = -1;
    ap      = -1;
    if (m_lock < 0) begin
      for (int k = 0; k < NP; k++) begin
        int p;
        p = (m_ptr + k) % NP;
        f = bus.idata[p*DW +: DW];
        if (win < 0 && v[p] && f[65:64] == T_HEAD) win = p;
      end
      if (win >= 0 && load_ok) er[win] = 1'b1;
    end else begin
      er[m_lock] = load_ok;
      eg[m_lock] = 1'b1;
    end
    chk("iready", bus.iready, er);
    chk("ogrant", bus.ogrant, eg);
    chk("ovalid", bus.ovalid, m_ov);
    if (m_ov) begin
      chk("odata", bus.odata, m_od);
      chk("ovch", bus.ovch, m_ovc);
    end
    if (bus.ovalid && bus.oready) begin
      out_q.push_back(bus.odata);
      out_cyc.push_back(cyc);
    end
    acc = er & v;
    for (int p = 0; p < NP; p++) if (acc[p]) ap = p;
    if (ap >= 0) begin
      f     = q[ap][0][65:0];
      m_ovc = q[ap][0][67:66];
      void'(q[ap].pop_front());
      m_od  = f;
      m_ov  = 1'b1;
      if (m_lock < 0) m_lock = ap;
      else if (f[65:64] == T_TAIL) begin
        m_ptr  = (m_lock + 1) % NP;
        m_lock = -1;
      end
    end else if (bus.oready) begin
      m_ov = 1'b0;
    end
  endtask

  task automatic cycle();
    drive();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_until(input int n, input int budget);
    int c;
    c = 0;
    while (out_q.size() < n && c < budget) begin
      cycle();
      c++;
    end
    chk("run_until_done", out_q.size() >= n, 1'b1);
  endtask

  task automatic chk_seq(input string nm);
    int mism;
    mism = -1;
    chk({nm, "_len"}, out_q.size(), exp_l.size());
    for (int i = 0; i < out_q.size() && i < exp_l.size(); i++)
      if (mism < 0 && out_q[i] !== exp_l[i]) mism = i;
    chk({nm, "_order"}, mism, -1);
  endtask

  task automatic do_reset(input bit clr);
    rst_ = 1'b0;
    #1;
    chk("rst_ovalid", bus.ovalid, 1'b0);
    chk("rst_ogrant", bus.ogrant, 4'b0);
    chk("rst_iready", bus.iready, 4'b0);
    chk("rst_odata", bus.odata, 66'b0);
    chk("rst_ovch", bus.ovch, 2'b0);
`ifdef FLIT_MUX_CNT_EN
    chk("rst_ocount", ocount, 32'b0);
`endif
    m_lock = -1;
    m_ptr  = 0;
    m_ov   = 1'b0;
    if (clr) for (int p = 0; p < NP; p++) q[p].delete();
    bus.ivalid = '0;
    @(negedge clk);
    rst_ = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [63:0] rnd;
    logic [65:0] f;
    int          hp [$];
    int          cnt [NP];
    int          n, mism;

    bus.ivalid = '0;
    bus.idata  = '0;
    bus.ivch   = '0;
    bus.oready = 1'b0;
    #2;

    // IDLE arbitration vectors: v, per-port types, port of a prior packet
    // (sets the pointer to prev+1), expected iready.
    tv[0] = '{4'b0000, 8'h55, -1, 4'b0000};
    tv[1] = '{4'b0101, 8'h55, -1, 4'b0001};
    tv[2] = '{4'b0101, 8'h55,  0, 4'b0100};
    tv[3] = '{4'b1111, 8'h55,  3, 4'b0001};
    tv[4] = '{4'b1001, 8'h55,  1, 4'b1000};
    tv[5] = '{4'b0011, 8'h55,  2, 4'b0001};
    tv[6] = '{4'b1000, 8'h80, -1, 4'b0000};
    tv[7] = '{4'b1110, 8'h6C, -1, 4'b1000};
    tv[8] = '{4'b0110, 8'h10,  0, 4'b0100};
    tv[9] = '{4'b1100, 8'h55,  2, 4'b1000};
    for (int i = 0; i < 10; i++) begin
      do_reset(1'b1);
      log_clear();
      if (tv[i].prev >= 0) begin
        push_pkt(tv[i].prev, 0);
        run_until(2, 20);
      end
      @(negedge clk);
      for (int p = 0; p < NP; p++) begin
        rnd = {$urandom, $urandom};
        f   = {tv[i].ty[2*p +: 2], rnd};
        bus.ivalid[p]         = tv[i].v[p];
        bus.idata[p*DW +: DW] = f;
      end
      bus.oready = 1'b1;
      #1;
      chk($sformatf("vec%0d_iready", i), bus.iready, tv[i].er);
      chk($sformatf("vec%0d_ogrant", i), bus.ogrant, 4'b0);
      bus.ivalid = '0;
    end

    // Single 22-flit packet on port 1, then pointer must sit at 2.
    do_reset(1'b1);
    log_clear();
    push_pkt(1, 20);
    run_until(22, 100);
    chk_seq("single");
    log_clear();
    push_pkt(1, 0);
    push_pkt(2, 0);
    run_until(4, 50);
    chk("single_rrptr_first", out_q[0][3:0], 4'd2);
    chk("single_rrptr_second", out_q[2][3:0], 4'd1);

    // Contention between ports 0 and 2.
    do_reset(1'b1);
    log_clear();
    push_pkt(0, 2);
    push_pkt(2, 2);
    run_until(8, 60);
    chk_seq("contend");
    chk("contend_nobubble", out_cyc[7] - out_cyc[0], 7);

    // Fairness: two 3-flit packets queued on every port.
    do_reset(1'b1);
    log_clear();
    for (int r = 0; r < 2; r++) for (int p = 0; p < NP; p++) push_pkt(p, 1);
    run_until(24, 100);
    for (int i = 0; i < out_q.size(); i++)
      if (out_q[i][65:64] == T_HEAD) hp.push_back(int'(out_q[i][3:0]));
    chk("fair_nheads", hp.size(), 8);
    for (int i = 0; i < 8; i++) chk($sformatf("fair_order%0d", i), hp[i], i % NP);
    for (int p = 0; p < NP; p++) cnt[p] = 0;
    for (int i = 0; i < 12; i++) cnt[out_q[i][3:0]]++;
    for (int p = 0; p < NP; p++) chk($sformatf("fair_share%0d", p), cnt[p], 3);
    chk("fair_nobubble", out_cyc[23] - out_cyc[0], 23);

    // Backpressure mid-packet.
    do_reset(1'b1);
    log_clear();
    push_pkt(1, 20);
    repeat (8) cycle();
    or_pct = 0;
    repeat (5) cycle();
    chk("bp_hold", bus.odata, exp_l[7]);
    chk("bp_ovalid", bus.ovalid, 1'b1);
    chk("bp_iready", bus.iready, 4'b0);
    or_pct = 100;
    run_until(22, 100);
    chk_seq("bp");

    // Stray DATA on port 3 while idle.
    do_reset(1'b1);
    log_clear();
    push_flit(3, T_DATA, 2'b00);
    exp_l.delete();
    repeat (10) cycle();
    chk("stray_out", out_q.size(), 0);
    chk("stray_ovalid", bus.ovalid, 1'b0);
    chk("stray_iready3", bus.iready[3], 1'b0);
    q[3].delete();

    // Reset in the middle of a port-1 packet; remainder stalls, port 0 flows.
    do_reset(1'b1);
    log_clear();
    push_pkt(1, 6);
    repeat (4) cycle();
    chk("mid_ogrant", bus.ogrant, 4'b0010);
    do_reset(1'b0);
    log_clear();
    push_pkt(0, 3);
    run_until(5, 60);
    chk_seq("post_rst");
    repeat (5) cycle();
    chk("post_rst_no_extra", out_q.size(), 5);
    q[1].delete();

    // Randomised traffic.
    do_reset(1'b1);
    log_clear();
    valid_pct = 70;
    or_pct    = 70;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      int p, nd;
      p  = int'($urandom_range(NP - 1));
      nd = int'($urandom_range(5));
      push_pkt(p, nd);
      n += nd + 2;
    end
    run_until(n, 4000);
    mism = 0;
    for (int p = 0; p < NP; p++) begin
      logic [65:0] a [$];
      logic [65:0] e [$];
      foreach (out_q[i]) if (out_q[i][3:0] == 4'(p)) a.push_back(out_q[i]);
      foreach (exp_l[i]) if (exp_l[i][3:0] == 4'(p)) e.push_back(exp_l[i]);
      if (a.size() != e.size()) mism++;
      else foreach (a[i]) if (a[i] !== e[i]) mism++;
    end
    chk("rand_port_order", mism, 0);
`ifdef FLIT_MUX_CNT_EN
    chk("rand_ocount", ocount, out_q.size());
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
